// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Bundles the request side (EX/MEM stage) and the data-memory side of the
//   load/store sequencer into one interface.
//   Request:  req_valid, req_ready, req_store, req_size[1:0], req_addr[31:0],
//             req_wdata[31:0]
//   Memory:   mem_en, mem_we, mem_addr[31:0], mem_be[3:0], mem_wdata[31:0],
//             mem_ack, mem_rdata[31:0]
//   Result:   ext_sel[1:0], align_data[31:0], done, err
//   Modports: slave  = the controller itself
//             master = the environment driving requests and modelling memory
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic [1:0]  ext_sel;
  logic [31:0] align_data;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_store, req_size, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    output ext_sel, align_data, done, err
  );

  modport master (
    output req_valid, req_store, req_size, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    input  ext_sel, align_data, done, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one data-memory load or store per accepted request. Misaligned
//   requests finish immediately with err; aligned ones drive the memory strobe
//   with byte enables and lane-replicated write data until mem_ack arrives or
//   TIMEOUT access cycles pass. Loads return the addressed bytes shifted down
//   to bit 0 (align_data) together with the extension-mux select (ext_sel).
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - mem_access_ctrl_if.slave (request, memory and result signals)
//   Parameter:
//     TIMEOUT - access cycles without mem_ack before aborting (1..255)
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  mem_access_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        req_store_q;
  logic [1:0]  ext_code_q;
  logic [1:0]  req_ofs_q;
  logic [7:0]  wait_cnt;

  logic        misaligned;
  logic [1:0]  ext_code;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Decode the incoming request: alignment, byte enables, replicated store
  // data and the extension-mux code. Size 3 behaves exactly like a word.
  always_comb begin
    misaligned = 1'b0;
    ext_code   = 2'd0;
    be_next    = 4'b1111;
    wdata_next = bus.req_wdata;
    case (bus.req_size)
      2'd1: begin
        misaligned = bus.req_addr[0];
        ext_code   = 2'd1;
        be_next    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{bus.req_wdata[15:0]}};
      end
      2'd2: begin
        ext_code   = 2'd2;
        be_next    = 4'b0001 << bus.req_addr[1:0];
        wdata_next = {4{bus.req_wdata[7:0]}};
      end
      default: begin
        misaligned = |bus.req_addr[1:0];
      end
    endcase
  end

  // Main sequencer. Every output is a register so downstream logic sees
  // glitch-free strobes; the memory-side buses are loaded once at accept and
  // held for the whole access. The timeout counter counts completed ACCESS
  // cycles, so an ack in the final allowed cycle still wins over expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req_store_q    <= 1'b0;
      ext_code_q     <= 2'd0;
      req_ofs_q      <= 2'd0;
      wait_cnt       <= 8'd0;
      bus.req_ready  <= 1'b1;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.mem_be     <= 4'd0;
      bus.mem_wdata  <= 32'd0;
      bus.ext_sel    <= 2'd0;
      bus.align_data <= 32'd0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            req_store_q   <= bus.req_store;
            ext_code_q    <= ext_code;
            req_ofs_q     <= bus.req_addr[1:0];
            bus.req_ready <= 1'b0;
            if (misaligned) begin
              state          <= FIN;
              bus.done       <= 1'b1;
              bus.err        <= 1'b1;
              bus.ext_sel    <= ext_code;
              bus.align_data <= 32'd0;
            end else begin
              state         <= ACCESS;
              wait_cnt      <= 8'd0;
              bus.mem_en    <= 1'b1;
              bus.mem_we    <= bus.req_store;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_be    <= be_next;
              bus.mem_wdata <= wdata_next;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack || (wait_cnt == LAST_WAIT)) begin
            state       <= FIN;
            bus.mem_en  <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.done    <= 1'b1;
            bus.err     <= ~bus.mem_ack;
            bus.ext_sel <= ext_code_q;
            if (!bus.mem_ack) begin
              bus.align_data <= 32'd0;
            end else if (!req_store_q) begin
              bus.align_data <= bus.mem_rdata >> {req_ofs_q, 3'b000};
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FIN: begin
          state         <= IDLE;
          bus.done      <= 1'b0;
          bus.err       <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.mem_en    <= 1'b0;
          bus.mem_we    <= 1'b0;
          bus.done      <= 1'b0;
          bus.err       <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Drives directed and random load/store requests into mem_access_ctrl while
//   modelling the data memory. A transaction-level model (byte counts, masks,
//   shifts) sets the expected outputs for every cycle; a single checker
//   process compares them on the falling edge and also resolves the literal
//   expectations posted by the stimulus.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;
  localparam int NO_ACK  = 1000;

  logic clk;
  logic rst;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs, written only by the stimulus process.
  logic        check_en;
  logic        exp_ready, exp_en, exp_we, exp_done, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_align;
  logic [3:0]  exp_be;
  logic [1:0]  exp_ext;

  // Literal expectation mailbox: stimulus posts, checker consumes.
  string       lit_name;
  logic [31:0] lit_act, lit_exp;
  int          lit_seq;

  // Checker-owned counters and observations.
  int          total, bad, lit_ack;
  int          en_cycles, done_count;
  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr;
  logic        last_we, last_err;

  function automatic int bytes_of(input logic [1:0] sz);
    return (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
  endfunction

  function automatic logic [1:0] ext_of(input logic [1:0] sz);
    return (sz == 2'd3) ? 2'd0 : sz;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] ad);
    int m;
    m = ((1 << bytes_of(sz)) - 1) << int'(ad[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    int n;
    n = bytes_of(sz);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(wd >> (8 * (i % n)));
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Checker: one comparison pass per falling edge.
  initial begin
    total = 0; bad = 0; lit_ack = 0;
    en_cycles = 0; done_count = 0;
    last_be = '0; last_wdata = '0; last_addr = '0; last_we = 1'b0; last_err = 1'b0;
    forever begin
      @(negedge clk);
      if (check_en && !rst) begin
        checkOutput("req_ready",  32'(bus.req_ready), 32'(exp_ready));
        checkOutput("mem_en",     32'(bus.mem_en),    32'(exp_en));
        checkOutput("done",       32'(bus.done),      32'(exp_done));
        checkOutput("err",        32'(bus.err),       32'(exp_err));
        checkOutput("ext_sel",    32'(bus.ext_sel),   32'(exp_ext));
        checkOutput("align_data", bus.align_data,     exp_align);
        if (exp_en) begin
          checkOutput("mem_we",    32'(bus.mem_we), 32'(exp_we));
          checkOutput("mem_addr",  bus.mem_addr,    exp_addr);
          checkOutput("mem_be",    32'(bus.mem_be), 32'(exp_be));
          checkOutput("mem_wdata", bus.mem_wdata,   exp_wdata);
        end
      end
      if (bus.mem_en) begin
        en_cycles++;
        last_be    = bus.mem_be;
        last_wdata = bus.mem_wdata;
        last_addr  = bus.mem_addr;
        last_we    = bus.mem_we;
      end
      if (bus.done) begin
        done_count++;
        last_err = bus.err;
      end
      if (lit_seq != lit_ack) begin
        checkOutput(lit_name, lit_act, lit_exp);
        lit_ack = lit_seq;
      end
    end
  end

  task automatic checkLiteral(input string name, input logic [31:0] act, input logic [31:0] want);
    lit_name = name;
    lit_act  = act;
    lit_exp  = want;
    lit_seq++;
    @(posedge clk); #1;
  endtask

  // One full request: accept, access with memory ack in ACCESS cycle ack_at
  // (1-based), one FIN cycle. Entered and left at posedge+1 in IDLE.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic [31:0] ad,
                               input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    logic ack;
    logic mis;
    mis = (int'(ad[1:0]) % bytes_of(sz)) != 0;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_size  = sz;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.req_valid = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    exp_ready = 1'b0;
    if (mis) begin
      exp_done  = 1'b1;
      exp_err   = 1'b1;
      exp_ext   = ext_of(sz);
      exp_align = 32'd0;
      bus.mem_ack = 1'($urandom);
    end else begin
      exp_en    = 1'b1;
      exp_we    = st;
      exp_addr  = ad & 32'hFFFF_FFFC;
      exp_be    = be_of(sz, ad);
      exp_wdata = wdata_of(sz, wd);
      for (int k = 1; k <= TIMEOUT; k++) begin
        ack = (k == ack_at);
        bus.mem_ack   = ack;
        bus.mem_rdata = ack ? rd : $urandom;
        bus.req_valid = 1'($urandom);
        bus.req_addr  = $urandom;
        @(posedge clk); #1;
        if (ack || k == TIMEOUT) begin
          exp_en   = 1'b0;
          exp_we   = 1'b0;
          exp_done = 1'b1;
          exp_err  = !ack;
          exp_ext  = ext_of(sz);
          if (!ack) exp_align = 32'd0;
          else if (!st) exp_align = rd >> (8 * ad[1:0]);
          break;
        end
      end
      bus.mem_ack   = 1'($urandom);
      bus.req_valid = 1'($urandom);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic setResetExpect();
    exp_ready = 1'b1; exp_en = 1'b0; exp_we = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_ext = 2'd0; exp_align = '0;
  endtask

  initial begin
    int e0, d0;
    logic        en_now, done_now;
    logic        st;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          r, ack_at;

    lit_seq = 0;
    check_en = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    setResetExpect();

    repeat (2) @(posedge clk);
    #1;
    checkLiteral("rst_ready", 32'(bus.req_ready), 32'd1);
    checkLiteral("rst_mem_en", 32'(bus.mem_en), 32'd0);
    checkLiteral("rst_done", 32'(bus.done), 32'd0);
    checkLiteral("rst_ext_sel", 32'(bus.ext_sel), 32'd0);
    checkLiteral("rst_align", bus.align_data, 32'd0);
    rst = 1'b0;
    check_en = 1'b1;
    @(posedge clk); #1;

    // 1: word load, ack after two wait cycles
    e0 = en_cycles;
    applyStimulus(1'b0, 2'd0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    checkLiteral("t1_align", bus.align_data, 32'hDEADBEEF);
    checkLiteral("t1_ext_sel", 32'(bus.ext_sel), 32'd0);
    checkLiteral("t1_be", 32'(last_be), 32'hF);
    checkLiteral("t1_en_cycles", 32'(en_cycles - e0), 32'd3);

    // 2: byte load from lane 3, immediate ack
    e0 = en_cycles;
    applyStimulus(1'b0, 2'd2, 32'h103, 32'h0, 1, 32'h11223344);
    checkLiteral("t2_align", bus.align_data, 32'h00000011);
    checkLiteral("t2_ext_sel", 32'(bus.ext_sel), 32'd2);
    checkLiteral("t2_be", 32'(last_be), 32'h8);
    checkLiteral("t2_en_cycles", 32'(en_cycles - e0), 32'd1);

    // 3: half store to upper half
    applyStimulus(1'b1, 2'd1, 32'h202, 32'h0000ABCD, 2, 32'h0);
    checkLiteral("t3_we", 32'(last_we), 32'd1);
    checkLiteral("t3_be", 32'(last_be), 32'hC);
    checkLiteral("t3_wdata", last_wdata, 32'hABCDABCD);
    checkLiteral("t3_addr", last_addr, 32'h200);

    // 4: misaligned word load
    e0 = en_cycles; d0 = done_count;
    applyStimulus(1'b0, 2'd0, 32'h101, 32'h0, 1, 32'h12345678);
    checkLiteral("t4_en_cycles", 32'(en_cycles - e0), 32'd0);
    checkLiteral("t4_done_count", 32'(done_count - d0), 32'd1);
    checkLiteral("t4_err", 32'(last_err), 32'd1);

    // 5: timeout, then ack in the last allowed cycle
    e0 = en_cycles;
    applyStimulus(1'b0, 2'd0, 32'h400, 32'h0, NO_ACK, 32'h0);
    checkLiteral("t5_to_en_cycles", 32'(en_cycles - e0), 32'd15);
    checkLiteral("t5_to_err", 32'(last_err), 32'd1);
    e0 = en_cycles;
    applyStimulus(1'b0, 2'd0, 32'h404, 32'h0, 15, 32'hCAFEF00D);
    checkLiteral("t5_last_en_cycles", 32'(en_cycles - e0), 32'd15);
    checkLiteral("t5_last_err", 32'(last_err), 32'd0);

    // 6: reset during the third access cycle
    d0 = done_count;
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'd0;
    bus.req_addr = 32'h300; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_ready = 1'b0; exp_en = 1'b1; exp_we = 1'b0;
    exp_addr = 32'h300; exp_be = 4'hF; exp_wdata = bus.req_wdata;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    en_now = bus.mem_en;
    done_now = bus.done;
    setResetExpect();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkLiteral("t6_en_dropped", 32'(en_now), 32'd0);
    checkLiteral("t6_done_at_rst", 32'(done_now), 32'd0);
    checkLiteral("t6_ready", 32'(bus.req_ready), 32'd1);
    checkLiteral("t6_no_done", 32'(done_count - d0), 32'd0);
    applyStimulus(1'b0, 2'd1, 32'h306, 32'h0, 2, 32'h89ABCDEF);
    checkLiteral("t6_after_align", bus.align_data, 32'h000089AB);

    // Random traffic against the model.
    for (int t = 0; t < 60; t++) begin
      st = 1'($urandom);
      sz = 2'($urandom);
      ad = $urandom;
      if ($urandom_range(3) != 0) ad = ad & ~(32'(bytes_of(sz)) - 32'd1);
      r = $urandom_range(7);
      if (r <= 4)      ack_at = r + 1;
      else if (r == 5) ack_at = TIMEOUT;
      else if (r == 6) ack_at = NO_ACK;
      else             ack_at = $urandom_range(1, 10);
      applyStimulus(st, sz, ad, $urandom, ack_at, $urandom);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
